// File: rtl/clint_timer.sv
// Core-local interruptor: free-running 64-bit mtime with prescaler, mtimecmp
// compare driving mtip, and a software msip bit, behind a one-slot MMIO port.
module clint_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        time_en,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [63:0] mtime,
  output logic        mtip,
  output logic        msip
);

  localparam int unsigned   PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  typedef enum logic [2:0] {
    R_NONE, R_MSIP, R_CMP_LO, R_CMP_HI, R_MT_LO, R_MT_HI
  } reg_sel_e;

  logic [PW-1:0] pre_cnt;
  logic [63:0]   mtimecmp;
  logic [31:0]   off;
  logic [31:0]   rdata_d;
  reg_sel_e      sel;
  logic          acc, wr, tick;

  assign req_ready = !resp_valid || resp_ready;
  assign acc       = req_valid && req_ready;
  assign wr        = acc && req_we;
  assign tick      = time_en && (pre_cnt == PMAX);

  // Addresses below the base wrap to a huge offset, so one upper-bits test
  // covers both ends of the window.
  assign off = req_addr - BASE_ADDR;

  always_comb begin
    sel = R_NONE;
    if (req_addr[1:0] == 2'b00 && off[31:16] == 16'h0) begin
      case (off[15:0])
        16'h0000: sel = R_MSIP;
        16'h4000: sel = R_CMP_LO;
        16'h4004: sel = R_CMP_HI;
        16'hBFF8: sel = R_MT_LO;
        16'hBFFC: sel = R_MT_HI;
        default:  sel = R_NONE;
      endcase
    end
  end

  always_comb begin
    rdata_d = '0;
    case (sel)
      R_MSIP:   rdata_d = {31'h0, msip};
      R_CMP_LO: rdata_d = mtimecmp[31:0];
      R_CMP_HI: rdata_d = mtimecmp[63:32];
      R_MT_LO:  rdata_d = mtime[31:0];
      R_MT_HI:  rdata_d = mtime[63:32];
      default:  rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt    <= '0;
      mtime      <= '0;
      mtimecmp   <= '1;
      msip       <= 1'b0;
      mtip       <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (time_en) pre_cnt <= (pre_cnt == PMAX) ? '0 : pre_cnt + PW'(1);

      // A software write to either half swallows a coincident tick.
      if (wr && sel == R_MT_LO)      mtime[31:0]  <= req_wdata;
      else if (wr && sel == R_MT_HI) mtime[63:32] <= req_wdata;
      else if (tick)                 mtime        <= mtime + 64'd1;

      if (wr && sel == R_CMP_LO) mtimecmp[31:0]  <= req_wdata;
      if (wr && sel == R_CMP_HI) mtimecmp[63:32] <= req_wdata;
      if (wr && sel == R_MSIP)   msip            <= req_wdata[0];

      mtip <= (mtime >= mtimecmp);

      if (acc) begin
        resp_valid <= 1'b1;
        resp_err   <= (sel == R_NONE);
        resp_rdata <= req_we ? 32'h0 : rdata_d;
      end else if (resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: two instances (PRESCALE 1 and 4) share one bus and
// are compared every cycle against a register-level reference model.
module tb_clint_timer;

  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam int P [2] = '{1, 4};

  logic        clk = 1'b0;
  logic        rst, time_en, req_valid, req_we, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic        rr_w [2];
  logic        rv_w [2];
  logic [31:0] rd_w [2];
  logic        re_w [2];
  logic [63:0] mt_w [2];
  logic        ti_w [2];
  logic        si_w [2];

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [63:0] m_mt [2];
  logic [63:0] m_cmp [2];
  logic        m_msip [2];
  logic        m_mtip [2];
  int          m_pre [2];
  logic [31:0] m_rd [2];
  logic        m_rv, m_err;

  always #5 clk = ~clk;

  clint_timer #(.BASE_ADDR(BASE), .PRESCALE(1)) u0 (
    .clk(clk), .rst(rst), .time_en(time_en), .req_valid(req_valid),
    .req_ready(rr_w[0]), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(rv_w[0]), .resp_ready(resp_ready),
    .resp_rdata(rd_w[0]), .resp_err(re_w[0]), .mtime(mt_w[0]),
    .mtip(ti_w[0]), .msip(si_w[0]));

  clint_timer #(.BASE_ADDR(BASE), .PRESCALE(4)) u4 (
    .clk(clk), .rst(rst), .time_en(time_en), .req_valid(req_valid),
    .req_ready(rr_w[1]), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(rv_w[1]), .resp_ready(resp_ready),
    .resp_rdata(rd_w[1]), .resp_err(re_w[1]), .mtime(mt_w[1]),
    .mtip(ti_w[1]), .msip(si_w[1]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 0 = error, 1 msip, 2 cmp lo, 3 cmp hi, 4 mtime lo, 5 mtime hi
  function automatic int dec(input logic [31:0] a);
    logic [31:0] o;
    if (a[1:0] != 2'b00 || a < BASE || a > BASE + 32'hFFFF) return 0;
    o = a - BASE;
    case (o)
      32'h0000: return 1;
      32'h4000: return 2;
      32'h4004: return 3;
      32'hBFF8: return 4;
      32'hBFFC: return 5;
      default:  return 0;
    endcase
  endfunction

  task automatic model_edge();
    logic        acc, tick;
    int          d;
    logic [63:0] omt, ocmp;
    logic [31:0] rd;
    acc = req_valid && (!m_rv || resp_ready);
    d   = dec(req_addr);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_mt[i] = 64'h0; m_cmp[i] = '1; m_msip[i] = 1'b0; m_mtip[i] = 1'b0;
        m_pre[i] = 0; m_rd[i] = 32'h0;
      end else begin
        omt  = m_mt[i];
        ocmp = m_cmp[i];
        tick = time_en && (m_pre[i] == P[i] - 1);
        if (time_en) m_pre[i] = (m_pre[i] + 1) % P[i];
        m_mtip[i] = (omt >= ocmp);
        if (acc) begin
          case (d)
            1: rd = {31'h0, m_msip[i]};
            2: rd = ocmp[31:0];
            3: rd = ocmp[63:32];
            4: rd = omt[31:0];
            5: rd = omt[63:32];
            default: rd = 32'h0;
          endcase
          m_rd[i] = req_we ? 32'h0 : rd;
          if (req_we) begin
            case (d)
              1: m_msip[i] = req_wdata[0];
              2: m_cmp[i][31:0] = req_wdata;
              3: m_cmp[i][63:32] = req_wdata;
              4: m_mt[i][31:0] = req_wdata;
              5: m_mt[i][63:32] = req_wdata;
              default: ;
            endcase
          end
        end
        if (tick && !(acc && req_we && (d == 4 || d == 5))) m_mt[i] = omt + 64'd1;
      end
    end
    if (rst) begin
      m_rv = 1'b0; m_err = 1'b0;
    end else if (acc) begin
      m_rv = 1'b1; m_err = (d == 0);
    end else if (resp_ready) begin
      m_rv = 1'b0;
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("mtime%0d", i), mt_w[i], m_mt[i]);
      chk($sformatf("mtip%0d", i), 64'(ti_w[i]), 64'(m_mtip[i]));
      chk($sformatf("msip%0d", i), 64'(si_w[i]), 64'(m_msip[i]));
      chk($sformatf("rvalid%0d", i), 64'(rv_w[i]), 64'(m_rv));
      chk($sformatf("rready%0d", i), 64'(rr_w[i]), 64'(!m_rv || resp_ready));
      if (m_rv) begin
        chk($sformatf("rdata%0d", i), 64'(rd_w[i]), 64'(m_rd[i]));
        chk($sformatf("rerr%0d", i), 64'(re_w[i]), 64'(m_err));
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // Presents one request for exactly one cycle; the caller ensures req_ready.
  task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] data);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data;
    chk("req_ready_pre", 64'(rr_w[0]), 64'd1);
    cyc();
    req_valid = 1'b0;
  endtask

  logic [31:0] held;
  logic [31:0] addrs [9];

  initial begin
    rst = 1'b1; time_en = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    resp_ready = 1'b1; req_addr = BASE; req_wdata = 32'h0;
    m_rv = 1'b0; m_err = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_mt[i] = 0; m_cmp[i] = '1; m_msip[i] = 0; m_mtip[i] = 0; m_pre[i] = 0; m_rd[i] = 0;
    end

    // reset state
    cyc(); cyc();
    chk("rst_mtime", mt_w[0], 64'd0);
    chk("rst_mtip", 64'(ti_w[0]), 64'd0);
    chk("rst_msip", 64'(si_w[1]), 64'd0);
    chk("rst_rvalid", 64'(rv_w[0]), 64'd0);
    chk("rst_rdata", 64'(rd_w[0]), 64'd0);
    chk("rst_rerr", 64'(re_w[0]), 64'd0);
    rst = 1'b0;

    // free-running count and read latency
    repeat (10) cyc();
    chk("t1_mtime10", mt_w[0], 64'd10);
    chk("t1_mtip", 64'(ti_w[0]), 64'd0);
    chk("t4_mtime_p4", mt_w[1], 64'd2);
    bus(1'b0, BASE + 32'hBFF8, 32'h0);
    chk("t1_rvalid", 64'(rv_w[0]), 64'd1);
    chk("t1_rdata", 64'(rd_w[0]), 64'd10);
    cyc();
    chk("t1_rvalid_clr", 64'(rv_w[0]), 64'd0);
    repeat (4) cyc();
    chk("t4_mtime16", mt_w[1], 64'd4);

    // freeze
    time_en = 1'b0;
    repeat (8) cyc();
    chk("t4_frozen0", mt_w[0], 64'd16);
    chk("t4_frozen4", mt_w[1], 64'd4);
    time_en = 1'b1;

    // write lands on a prescaled tick: tick is lost
    for (int k = 0; k < 8 && m_pre[1] != 3; k++) cyc();
    bus(1'b1, BASE + 32'hBFF8, 32'd7);
    chk("t4_wr_tick", mt_w[1], 64'd7);
    repeat (3) cyc();
    chk("t4_tick_lost", mt_w[1], 64'd7);
    cyc();
    chk("t4_next_tick", mt_w[1], 64'd8);

    // compare and mtip timing
    bus(1'b1, BASE + 32'h4000, 32'd20);
    bus(1'b1, BASE + 32'h4004, 32'd0);
    for (int k = 0; k < 40 && mt_w[0] != 64'd20; k++) cyc();
    chk("t2_reach20", mt_w[0], 64'd20);
    chk("t2_mtip_lo", 64'(ti_w[0]), 64'd0);
    cyc();
    chk("t2_mtip_rise", 64'(ti_w[0]), 64'd1);
    bus(1'b1, BASE + 32'h4000, 32'd100);
    chk("t2_mtip_hold", 64'(ti_w[0]), 64'd1);
    cyc();
    chk("t2_mtip_fall", 64'(ti_w[0]), 64'd0);

    // wrap at all-ones
    bus(1'b1, BASE + 32'h4000, 32'hFFFF_FFFF);
    bus(1'b1, BASE + 32'h4004, 32'hFFFF_FFFF);
    bus(1'b1, BASE + 32'hBFFC, 32'hFFFF_FFFF);
    bus(1'b1, BASE + 32'hBFF8, 32'hFFFF_FFFE);
    chk("t3_set", mt_w[0], 64'hFFFF_FFFF_FFFF_FFFE);
    cyc();
    chk("t3_ones", mt_w[0], '1);
    cyc();
    chk("t3_wrap", mt_w[0], 64'd0);
    chk("t3_mtip_ones", 64'(ti_w[0]), 64'd1);
    cyc();
    chk("t3_mtip_clr", 64'(ti_w[0]), 64'd0);

    // msip and error decode
    bus(1'b1, BASE, 32'h1);
    chk("t5_msip", 64'(si_w[0]), 64'd1);
    bus(1'b0, BASE + 32'h8, 32'h0);
    chk("t5_err8", 64'(re_w[0]), 64'd1);
    chk("t5_rd8", 64'(rd_w[0]), 64'd0);
    bus(1'b0, BASE + 32'h2, 32'h0);
    chk("t5_err2", 64'(re_w[0]), 64'd1);
    bus(1'b1, BASE + 32'h1_0000, 32'h0);
    chk("t5_err_win", 64'(re_w[0]), 64'd1);
    bus(1'b1, BASE + 32'h4002, 32'h0);
    bus(1'b0, BASE - 32'h4, 32'h0);
    chk("t5_err_below", 64'(re_w[0]), 64'd1);
    bus(1'b0, BASE + 32'h4000, 32'h0);
    chk("t5_cmp_kept", 64'(rd_w[0]), 64'hFFFF_FFFF);
    cyc();

    // backpressure, then reset with a response pending
    resp_ready = 1'b0;
    bus(1'b0, BASE + 32'hBFF8, 32'h0);
    held = rd_w[0];
    req_valid = 1'b1; req_we = 1'b1; req_addr = BASE; req_wdata = 32'h0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("t6_ready_lo", 64'(rr_w[0]), 64'd0);
      chk("t6_rdata_hold", 64'(rd_w[0]), 64'(held));
      chk("t6_msip_kept", 64'(si_w[0]), 64'd1);
    end
    rst = 1'b1;
    cyc();
    chk("t6_rvalid", 64'(rv_w[0]), 64'd0);
    chk("t6_mtime", mt_w[1], 64'd0);
    chk("t6_msip", 64'(si_w[0]), 64'd0);
    chk("t6_rdata", 64'(rd_w[0]), 64'd0);
    rst = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
    cyc();

    // random traffic
    addrs = '{BASE, BASE + 32'h4000, BASE + 32'h4004, BASE + 32'hBFF8,
              BASE + 32'hBFFC, BASE + 32'h8, BASE + 32'h4002,
              BASE + 32'h1_0000, BASE - 32'h4};
    for (int k = 0; k < 500; k++) begin
      rst        = ($urandom_range(0, 149) == 0);
      time_en    = ($urandom_range(0, 9) != 0);
      resp_ready = ($urandom_range(0, 3) != 0);
      req_valid  = $urandom_range(0, 1) == 1;
      req_we     = $urandom_range(0, 1) == 1;
      req_addr   = ($urandom_range(0, 9) == 9) ? $urandom : addrs[$urandom_range(0, 8)];
      req_wdata  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 300) : $urandom;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
